// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment word checker: char codes, active-low segment patterns, rotation words.
// Pure definitions; no latency or flow control.
package seg7_pkg;

    localparam int NUM_DIGITS = 6;
    localparam int CODE_W     = 3;
    localparam int WORD_W     = NUM_DIGITS * CODE_W;

    localparam logic [CODE_W-1:0] CH_D     = 3'd0;
    localparam logic [CODE_W-1:0] CH_E     = 3'd1;
    localparam logic [CODE_W-1:0] CH_1     = 3'd2;
    localparam logic [CODE_W-1:0] CH_0     = 3'd3;
    localparam logic [CODE_W-1:0] CH_BLANK = 3'd4;

    // Index 0 of each pattern is segment a; a 0 lights the segment.
    localparam logic [0:6] SEG_D     = 7'b1000010;
    localparam logic [0:6] SEG_E     = 7'b0110000;
    localparam logic [0:6] SEG_1     = 7'b1001111;
    localparam logic [0:6] SEG_0     = 7'b0000001;
    localparam logic [0:6] SEG_BLANK = 7'b1111111;

    // HEX5..HEX0 = blank, blank, d, E, 1, 0
    localparam logic [WORD_W-1:0] ROT0_WORD = {CH_BLANK, CH_BLANK, CH_D, CH_E, CH_1, CH_0};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    // Rotation r is ROT0_WORD rotated toward HEX5 by r whole digits.
    function automatic logic [WORD_W-1:0] rot_word(input int r);
        logic [2*WORD_W-1:0] w_dbl;
        w_dbl = {ROT0_WORD, ROT0_WORD};
        return w_dbl[2*WORD_W-1-CODE_W*r -: WORD_W];
    endfunction

endpackage

// File: rtl/seg7_to_char.sv
// Maps an active-low segment pattern back to its char code; flags patterns the display never produces.
// Purely combinational, zero latency, no flow control.
module seg7_to_char
    import seg7_pkg::*;
(
    input  logic [0:6]        i_seg,
    output logic              o_known,
    output logic [CODE_W-1:0] o_code
);

    always_comb begin
        o_known = 1'b1;
        o_code  = CH_BLANK;
        case (i_seg)
            SEG_D:     o_code = CH_D;
            SEG_E:     o_code = CH_E;
            SEG_1:     o_code = CH_1;
            SEG_0:     o_code = CH_0;
            SEG_BLANK: o_code = CH_BLANK;
            default: begin
                o_known = 1'b0;
                o_code  = CH_D;
            end
        endcase
    end

endmodule

// File: rtl/seg7_word_decoder.sv
// Rebuilds the six-digit word from sampled segment patterns and reports which display rotation it matches.
// Digit stored 1 clk after its sample, word_valid the clk after digit 5; SEG7_STABLE_FILTER_EN debounces input.
module seg7_word_decoder
    import seg7_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int STABLE_CYCLES  = 4
)(
    input  logic              CLOCK_50,
    input  logic              Reset,
    input  logic [0:6]        seg_in,
    input  logic [2:0]        digit_idx,
    input  logic              seg_valid,
    output logic [WORD_W-1:0] char_word,
    output logic              word_valid,
    output logic [2:0]        rot_idx,
    output logic              rot_valid,
    output logic              err_char,
    output logic              err_seq
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    if (TIMEOUT_CYCLES < 2 || STABLE_CYCLES < 1) begin : g_bad_param
        $error("seg7_word_decoder: TIMEOUT_CYCLES must be >= 2 and STABLE_CYCLES >= 1");
    end

    state_t              r_state, w_state_nxt;
    logic [WORD_W-1:0]   r_store, w_word_nxt;
    logic [WORD_W-1:0]   r_char_word;
    logic [2:0]          r_rot_idx, w_rot_sel;
    logic                r_rot_valid, w_rot_hit;
    logic                r_err_char, r_err_seq;
    logic [2:0]          r_expect;
    logic [TW-1:0]       r_tmo;
    logic                w_known;
    logic [CODE_W-1:0]   w_code;
    logic                w_sample, w_timeout, w_is_repeat;
    logic                w_accept, w_complete, w_err_char_nxt, w_err_seq_nxt;

    seg7_to_char u_to_char (
        .i_seg   (seg_in),
        .o_known (w_known),
        .o_code  (w_code)
    );

`ifdef SEG7_STABLE_FILTER_EN
    localparam int  SW            = $clog2(STABLE_CYCLES + 1);
    localparam bit  IGNORE_REPEAT = 1'b0;

    logic [0:6]    r_prev_seg;
    logic [2:0]    r_prev_idx;
    logic          r_prev_vld;
    logic [SW-1:0] r_run, w_run_nxt;
    logic          w_same;

    assign w_same = seg_valid && r_prev_vld && (seg_in == r_prev_seg) && (digit_idx == r_prev_idx);

    always_comb begin
        w_run_nxt = '0;
        if (w_same)
            w_run_nxt = (r_run == SW'(STABLE_CYCLES)) ? r_run : r_run + SW'(1);
        else if (seg_valid)
            w_run_nxt = SW'(1);
    end

    // Fire once when the run first reaches the threshold; a saturated run stays silent.
    assign w_sample = seg_valid && (w_run_nxt == SW'(STABLE_CYCLES)) &&
                      !(w_same && (r_run == SW'(STABLE_CYCLES)));

    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            r_prev_seg <= '0;
            r_prev_idx <= '0;
            r_prev_vld <= 1'b0;
            r_run      <= '0;
        end else begin
            r_prev_seg <= seg_in;
            r_prev_idx <= digit_idx;
            r_prev_vld <= seg_valid;
            r_run      <= w_run_nxt;
        end
    end
`else
    localparam bit  IGNORE_REPEAT = 1'b1;

    assign w_sample = seg_valid;
`endif

    assign w_timeout   = (r_tmo == TW'(TIMEOUT_CYCLES - 1));
    assign w_is_repeat = (digit_idx == r_expect - 3'd1);

    // Word as it would look with the current sample written into its slot.
    always_comb begin
        w_word_nxt = r_store;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digit_idx == 3'(i))
                w_word_nxt[CODE_W*i +: CODE_W] = w_code;
        end
    end

    // Descending scan so the lowest matching rotation wins.
    always_comb begin
        w_rot_hit = 1'b0;
        w_rot_sel = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (w_word_nxt == rot_word(i)) begin
                w_rot_hit = 1'b1;
                w_rot_sel = 3'(i);
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (Reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_accept       = 1'b0;
        w_complete     = 1'b0;
        w_err_char_nxt = 1'b0;
        w_err_seq_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_sample) begin
                    if (!w_known) begin
                        w_err_char_nxt = 1'b1;
                    end else if (digit_idx == 3'd0) begin
                        w_accept    = 1'b1;
                        w_state_nxt = ST_COLLECT;
                    end
                end
            end
            ST_COLLECT: begin
                if (w_sample) begin
                    if (!w_known) begin
                        w_err_char_nxt = 1'b1;
                        w_state_nxt    = ST_IDLE;
                    end else if (digit_idx == r_expect) begin
                        w_accept = 1'b1;
                        if (digit_idx == 3'(NUM_DIGITS - 1)) begin
                            w_complete  = 1'b1;
                            w_state_nxt = ST_DONE;
                        end
                    end else if (!(IGNORE_REPEAT && w_is_repeat)) begin
                        w_err_seq_nxt = 1'b1;
                        // A fresh digit 0 restarts the word instead of dropping it.
                        if (digit_idx == 3'd0)
                            w_accept = 1'b1;
                        else
                            w_state_nxt = ST_IDLE;
                    end
                end
                if (!w_accept && !w_err_char_nxt && !w_err_seq_nxt && w_timeout) begin
                    w_err_seq_nxt = 1'b1;
                    w_state_nxt   = ST_IDLE;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        word_valid = (r_state == ST_DONE);
    end

    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            r_store     <= '0;
            r_char_word <= '0;
            r_rot_idx   <= '0;
            r_rot_valid <= 1'b0;
            r_err_char  <= 1'b0;
            r_err_seq   <= 1'b0;
            r_expect    <= '0;
            r_tmo       <= '0;
        end else begin
            r_err_char <= w_err_char_nxt;
            r_err_seq  <= w_err_seq_nxt;

            if (w_accept)
                r_store <= w_word_nxt;

            if (w_complete) begin
                r_char_word <= w_word_nxt;
                r_rot_valid <= w_rot_hit;
                r_rot_idx   <= w_rot_hit ? w_rot_sel : 3'd0;
            end

            if (w_accept)
                r_expect <= digit_idx + 3'd1;
            else if (w_state_nxt == ST_IDLE)
                r_expect <= '0;

            if (r_state != ST_COLLECT || w_accept)
                r_tmo <= '0;
            else if (r_tmo != TW'(TIMEOUT_CYCLES))
                r_tmo <= r_tmo + TW'(1);
        end
    end

    assign char_word = r_char_word;
    assign rot_idx   = r_rot_idx;
    assign rot_valid = r_rot_valid;
    assign err_char  = r_err_char;
    assign err_seq   = r_err_seq;

endmodule

// File: tb/tb_seg7_word_decoder.sv
// Bench for seg7_word_decoder: directed words plus random word streams checked against a digit-list model.
module tb_seg7_word_decoder;

    localparam int T = 1023;
    localparam int S = 4;
`ifdef SEG7_STABLE_FILTER_EN
    localparam int HOLD = S;
    localparam bit FILT = 1'b1;
`else
    localparam int HOLD = 1;
    localparam bit FILT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [0:6]  seg;
    logic [2:0]  idx;
    logic        vld;
    logic [17:0] char_word;
    logic        word_valid;
    logic [2:0]  rot_idx;
    logic        rot_valid, err_char, err_seq;

    int n_checks = 0;
    int n_fail   = 0;

    // Index = char code: d, E, 1, 0, blank (a..g, active low)
    logic [6:0] pat_tab [5] = '{7'b1000010, 7'b0110000, 7'b1001111, 7'b0000001, 7'b1111111};
    // Rotation 0 by HEX index (HEX0 first)
    int rot0_hex [6] = '{3, 2, 1, 0, 4, 4};

    int m_dig[$];
    bit m_active;
    int m_word [6];
    int m_rot_idx;
    bit m_rot_valid;
    bit e_wv, e_ec, e_es;

    always #5 clk = ~clk;

    seg7_word_decoder #(.TIMEOUT_CYCLES(T), .STABLE_CYCLES(S)) dut (
        .CLOCK_50   (clk),
        .Reset      (rst),
        .seg_in     (seg),
        .digit_idx  (idx),
        .seg_valid  (vld),
        .char_word  (char_word),
        .word_valid (word_valid),
        .rot_idx    (rot_idx),
        .rot_valid  (rot_valid),
        .err_char   (err_char),
        .err_seq    (err_seq)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int decode(input logic [6:0] p);
        for (int c = 0; c < 5; c++)
            if (pat_tab[c] == p) return c;
        return -1;
    endfunction

    function automatic logic [6:0] unknown_pat();
        logic [6:0] p;
        do p = 7'($urandom); while (decode(p) >= 0);
        return p;
    endfunction

    function automatic logic [17:0] model_word();
        logic [17:0] w;
        w = '0;
        for (int p = 0; p < 6; p++) w[3*p +: 3] = 3'(m_word[p]);
        return w;
    endfunction

    task automatic model_reset();
        m_dig.delete();
        m_active    = 1'b0;
        m_word      = '{default: 0};
        m_rot_idx   = 0;
        m_rot_valid = 1'b0;
        e_wv = 1'b0; e_ec = 1'b0; e_es = 1'b0;
    endtask

    task automatic model_finish();
        for (int p = 0; p < 6; p++) m_word[p] = m_dig[p];
        m_rot_valid = 1'b0;
        m_rot_idx   = 0;
        for (int r = 0; r < 6; r++) begin
            bit hit;
            hit = 1'b1;
            for (int p = 0; p < 6; p++)
                if (m_word[p] != rot0_hex[(p - r + 6) % 6]) hit = 1'b0;
            if (hit && !m_rot_valid) begin
                m_rot_valid = 1'b1;
                m_rot_idx   = r;
            end
        end
        e_wv     = 1'b1;
        m_active = 1'b0;
        m_dig.delete();
    endtask

    task automatic model_sample(input int i, input logic [6:0] p);
        int c;
        c = decode(p);
        e_wv = 1'b0; e_ec = 1'b0; e_es = 1'b0;
        if (c < 0) begin
            e_ec     = 1'b1;
            m_active = 1'b0;
            m_dig.delete();
        end else if (!m_active) begin
            if (i == 0) begin
                m_dig.delete();
                m_dig.push_back(c);
                m_active = 1'b1;
            end
        end else if (i == m_dig.size()) begin
            m_dig.push_back(c);
            if (m_dig.size() == 6) model_finish();
        end else if (FILT || i != m_dig.size() - 1) begin
            e_es = 1'b1;
            m_dig.delete();
            if (i == 0) m_dig.push_back(c);
            else        m_active = 1'b0;
        end
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, ":word_valid"}, 32'(word_valid), 32'(e_wv));
        check_eq({tag, ":err_char"},   32'(err_char),   32'(e_ec));
        check_eq({tag, ":err_seq"},    32'(err_seq),    32'(e_es));
        check_eq({tag, ":char_word"},  32'(char_word),  32'(model_word()));
        check_eq({tag, ":rot_idx"},    32'(rot_idx),    32'(m_rot_idx));
        check_eq({tag, ":rot_valid"},  32'(rot_valid),  32'(m_rot_valid));
    endtask

    task automatic send(input int i, input logic [6:0] p, input int gap);
        @(negedge clk);
        idx = 3'(i);
        seg = p;
        vld = 1'b1;
        model_sample(i, p);
        repeat (HOLD) @(posedge clk);
        #1 check_outputs("sample");
        @(negedge clk);
        vld = 1'b0;
        @(posedge clk);
        #1;
        e_wv = 1'b0; e_ec = 1'b0; e_es = 1'b0;
        check_outputs("gap");
        repeat (gap) @(posedge clk);
    endtask

    task automatic send_rot(input int r);
        for (int p = 0; p < 6; p++) send(p, pat_tab[rot0_hex[(p - r + 6) % 6]], 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int mode, r, c, kind;
        rst = 1'b1;
        vld = 1'b0;
        idx = '0;
        seg = '1;
        model_reset();
        repeat (3) @(posedge clk);
        #1 check_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        send_rot(0);
        check_eq("rot0_word", 32'(char_word), 32'o440123);

        send_rot(3);
        check_eq("rot3_idx", 32'(rot_idx), 32'd3);

        send(0, pat_tab[3], 0);
        send(1, pat_tab[2], 0);
        send(2, 7'b0000000, 0);
        check_eq("bad_char_hold", 32'(char_word), 32'o123440);

        send(0, pat_tab[3], 0);
        send(1, pat_tab[2], 0);
        send(3, pat_tab[0], 0);
        send_rot(1);

        for (int p = 0; p < 6; p++) send(p, pat_tab[4], 0);
        check_eq("blank_rot_valid", 32'(rot_valid), 32'd0);

        // Stall after digit 2: err_seq must appear exactly T clocks after it was accepted.
        send(0, pat_tab[3], 0);
        send(1, pat_tab[2], 0);
        send(2, pat_tab[1], 0);
        repeat (T - 2) @(posedge clk);
        #1 check_eq("tmo_early", 32'(err_seq), 32'd0);
        @(posedge clk);
        #1 check_eq("tmo_limit", 32'(err_seq), 32'd1);
        m_active = 1'b0;
        m_dig.delete();
        @(posedge clk);
        #1 check_outputs("tmo_after");

        for (int p = 0; p < 4; p++) send(p, pat_tab[rot0_hex[p]], 0);
        @(negedge clk);
        idx = 3'd4;
        seg = pat_tab[4];
        vld = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1 model_reset();
        check_outputs("mid_reset");
        @(negedge clk);
        rst = 1'b0;
        vld = 1'b0;
        send_rot(2);

`ifdef SEG7_STABLE_FILTER_EN
        send(0, pat_tab[3], 0);
        send(1, pat_tab[2], 0);
        @(negedge clk);
        idx = 3'd3;
        seg = pat_tab[0];
        vld = 1'b1;
        for (int k = 0; k < S - 1; k++) begin
            @(posedge clk);
            #1 check_eq("glitch", 32'(err_seq), 32'd0);
        end
        @(negedge clk);
        vld = 1'b0;
        @(posedge clk);
        send(2, pat_tab[1], 0);
        send(3, pat_tab[0], 0);
        send(4, pat_tab[4], 0);
        send(5, pat_tab[4], 0);
`endif

        for (int w = 0; w < 40; w++) begin
            mode = $urandom_range(0, 2);
            r    = $urandom_range(0, 5);
            for (int p = 0; p < 6; p++) begin
                c = (mode != 0) ? rot0_hex[(p - r + 6) % 6] : $urandom_range(0, 4);
                if ($urandom_range(0, 9) == 0) begin
                    kind = $urandom_range(0, 3);
                    case (kind)
                        0:       send(p, unknown_pat(), 0);
                        1:       send($urandom_range(0, 7), pat_tab[c], 0);
                        2:       send((p > 0) ? p - 1 : 0, pat_tab[c], 0);
                        default: send(0, pat_tab[c], 0);
                    endcase
                end
                send(p, pat_tab[c], $urandom_range(0, 2));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
